// File: rtl/screen_write_arbiter_if.sv
// Write-port bundle between the drawing clients, the arbiter and the screen RAM.
// The master side drives requests and clear_start; the slave side (the arbiter) answers.
interface screen_write_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int AW    = 11,
  parameter int DW    = 8
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    ack;
  logic                clear_start;
  logic                clear_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [DW-1:0]       wr_data;

  modport master (
    output req, req_addr, req_data, clear_start,
    input  ack, clear_busy, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req, req_addr, req_data, clear_start,
    output ack, clear_busy, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/screen_write_arbiter.sv
// Round-robin arbiter for the screen RAM write port, with a built-in full-RAM clear engine.
// The RAM write triple and clear_busy are registered; ack is combinational.
module screen_write_arbiter #(
  parameter int            N_REQ       = 3,
  parameter int            AW          = 11,
  parameter int            DW          = 8,
  parameter logic [DW-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  screen_write_arbiter_if.slave bus
);

  localparam int LW = $clog2(N_REQ);
  localparam int CW = LW + 1;

  typedef enum logic {ARB, CLEAR} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] last_q, last_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  logic          found;
  logic [LW-1:0] grant_idx;
  logic [CW-1:0] cand_wide;
  logic [LW-1:0] cand;

  // Search starts just after the last winner; one conditional subtract handles the wrap.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand_wide = '0;
    cand      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand_wide = {1'b0, last_q} + CW'(i);
      if (cand_wide >= CW'(N_REQ)) begin
        cand_wide = cand_wide - CW'(N_REQ);
      end
      cand = cand_wide[LW-1:0];
      if (!found && bus.req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    bus.ack = '0;
    if (!rst && state_q == ARB && !bus.clear_start && found) begin
      bus.ack[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      ARB: begin
        if (bus.clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else if (found) begin
          wr_en_d   = 1'b1;
          wr_addr_d = bus.req_addr[int'(grant_idx)*AW +: AW];
          wr_data_d = bus.req_data[int'(grant_idx)*DW +: DW];
          last_d    = grant_idx;
        end
      end
      CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = CLEAR_VALUE;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == {AW{1'b1}}) begin
          state_d = ARB;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB;
      last_q    <= LW'(N_REQ - 1);
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.clear_busy = busy_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;

endmodule

// File: tb/tb_screen_write_arbiter.sv
// Directed plus randomized bench for screen_write_arbiter against a transaction-level model
// that tracks the round-robin pointer and the remaining clear sweep.
module tb_screen_write_arbiter;

  localparam int            N_REQ = 3;
  localparam int            AW    = 11;
  localparam int            DW    = 8;
  localparam int            DEPTH = 1 << AW;
  localparam logic [DW-1:0] CLR   = 8'h00;

  logic clk;
  logic rst;

  screen_write_arbiter_if #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) bus ();

  screen_write_arbiter #(
    .N_REQ(N_REQ), .AW(AW), .DW(DW), .CLEAR_VALUE(CLR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Model state: pointer, clear progress and the expected registered outputs.
  int            m_last;
  bit            m_clear;
  int            m_next;
  logic          e_en;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic          e_busy;
  logic [N_REQ-1:0] last_ack;
  int            wr_count;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [N_REQ-1:0] r);
    for (int i = 1; i <= N_REQ; i++) begin
      int k;
      k = (m_last + i) % N_REQ;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last  = N_REQ - 1;
    m_clear = 0;
    m_next  = 0;
    e_en    = 1'b0;
    e_addr  = '0;
    e_data  = '0;
    e_busy  = 1'b0;
  endtask

  task automatic set_client(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_addr[k*AW +: AW] = a;
    bus.req_data[k*DW +: DW] = d;
  endtask

  task automatic check_regs(input string tag);
    check_output({tag, ".wr_en"},      bus.wr_en,      e_en);
    check_output({tag, ".wr_addr"},    bus.wr_addr,    e_addr);
    check_output({tag, ".wr_data"},    bus.wr_data,    e_data);
    check_output({tag, ".clear_busy"}, bus.clear_busy, e_busy);
  endtask

  // One clock: inputs already driven at the falling edge; check ack, advance model, check registers.
  task automatic apply_stimulus(input string tag);
    int               g;
    logic             cs;
    logic [N_REQ-1:0] ea;
    logic [AW-1:0]    ga;
    logic [DW-1:0]    gd;
    #1;
    g  = model_grant(bus.req);
    cs = bus.clear_start;
    ea = '0;
    ga = '0;
    gd = '0;
    if (g >= 0) begin
      ga = bus.req_addr[g*AW +: AW];
      gd = bus.req_data[g*DW +: DW];
    end
    if (!m_clear && !cs && g >= 0) ea[g] = 1'b1;
    last_ack = bus.ack;
    check_output({tag, ".ack"}, bus.ack, ea);
    @(posedge clk);
    if (m_clear) begin
      e_en   = 1'b1;
      e_addr = AW'(m_next);
      e_data = CLR;
      m_next++;
      if (m_next == DEPTH) begin
        m_clear = 0;
        e_busy  = 1'b0;
      end
    end else if (cs) begin
      m_clear = 1;
      m_next  = 0;
      e_busy  = 1'b1;
      e_en    = 1'b0;
    end else if (g >= 0) begin
      e_en   = 1'b1;
      e_addr = ga;
      e_data = gd;
      m_last = g;
    end else begin
      e_en = 1'b0;
    end
    @(negedge clk);
    check_regs(tag);
  endtask

  task automatic apply_reset();
    rst             = 1'b1;
    bus.req         = N_REQ'($urandom);
    bus.req_addr    = (N_REQ*AW)'({$urandom, $urandom});
    bus.req_data    = (N_REQ*DW)'($urandom);
    bus.clear_start = 1'($urandom);
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      check_output("reset.ack", bus.ack, '0);
      check_regs("reset");
      @(negedge clk);
    end
    bus.req         = '0;
    bus.clear_start = 1'b0;
    rst             = 1'b0;
  endtask

  initial begin
    int order_all[6];
    int order_drop[4];
    order_all  = '{0, 1, 2, 0, 1, 2};
    order_drop = '{0, 2, 0, 2};

    rst             = 1'b1;
    bus.req         = '0;
    bus.req_addr    = '0;
    bus.req_data    = '0;
    bus.clear_start = 1'b0;
    model_reset();

    $display("[TB] reset with random inputs");
    apply_reset();

    $display("[TB] single-client streaming");
    bus.req = 3'b010;
    set_client(1, 11'h1D2, 8'hFF);
    apply_stimulus("stream0");
    check_output("stream0.grant", last_ack, 3'b010);
    set_client(1, 11'h1D3, 8'hFF);
    apply_stimulus("stream1");
    check_output("stream1.grant", last_ack, 3'b010);
    set_client(1, 11'h1DD, 8'h80);
    apply_stimulus("stream2");
    check_output("stream2.grant", last_ack, 3'b010);
    check_output("stream2.addr", bus.wr_addr, 11'h1DD);
    bus.req = '0;
    apply_stimulus("stream_idle");

    $display("[TB] round-robin fairness");
    apply_reset();
    for (int k = 0; k < N_REQ; k++) set_client(k, AW'(16 * k + 1), DW'(k + 8'hA0));
    bus.req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus("rr_all");
      check_output("rr_all.order", last_ack, 3'b001 << order_all[i]);
    end
    bus.req = 3'b101;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus("rr_drop");
      check_output("rr_drop.order", last_ack, 3'b001 << order_drop[i]);
    end

    $display("[TB] randomized traffic");
    for (int i = 0; i < 200; i++) begin
      bus.req      = N_REQ'($urandom);
      bus.req_addr = (N_REQ*AW)'({$urandom, $urandom});
      bus.req_data = (N_REQ*DW)'($urandom);
      apply_stimulus("random");
    end

    $display("[TB] full clear while client 2 waits");
    bus.req = 3'b100;
    set_client(2, 11'h055, 8'h3C);
    bus.clear_start = 1'b1;
    apply_stimulus("clr_start");
    bus.clear_start = 1'b0;
    check_output("clr_start.busy", bus.clear_busy, 1'b1);
    for (int i = 0; i < DEPTH; i++) apply_stimulus("clr_sweep");
    check_output("clr_end.busy", bus.clear_busy, 1'b0);
    check_output("clr_end.addr", bus.wr_addr, 11'h7FF);
    apply_stimulus("clr_after");
    check_output("clr_after.grant", last_ack, 3'b100);

    $display("[TB] clear coincident with all requests, plus repeated clear_start");
    bus.req = 3'b111;
    bus.clear_start = 1'b1;
    apply_stimulus("clr2_start");
    check_output("clr2_start.noack", last_ack, 3'b000);
    bus.clear_start = 1'b0;
    wr_count = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.clear_start = (m_next == 11'h100) ? 1'b1 : 1'b0;
      apply_stimulus("clr2_sweep");
      if (bus.wr_en) wr_count++;
    end
    bus.clear_start = 1'b0;
    check_output("clr2.writes", wr_count, DEPTH);
    check_output("clr2.busy_low", bus.clear_busy, 1'b0);
    bus.req = '0;
    apply_stimulus("clr2_idle");

    $display("[TB] reset in the middle of a clear");
    bus.clear_start = 1'b1;
    apply_stimulus("clr3_start");
    bus.clear_start = 1'b0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (m_clear && e_addr == 11'h400) break;
      apply_stimulus("clr3_sweep");
    end
    check_output("clr3.reached", bus.wr_addr, 11'h400);
    rst = 1'b1;
    model_reset();
    #1;
    check_output("midrst.wr_en", bus.wr_en, 1'b0);
    check_output("midrst.busy", bus.clear_busy, 1'b0);
    check_output("midrst.addr", bus.wr_addr, 11'h000);
    @(negedge clk);
    rst = 1'b0;
    bus.req = 3'b001;
    set_client(0, 11'h2A5, 8'h5A);
    apply_stimulus("postrst");
    check_output("postrst.grant", last_ack, 3'b001);
    check_output("postrst.data", bus.wr_data, 8'h5A);
    bus.req = '0;
    apply_stimulus("postrst_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
